arbiter_4way_rr: RTL and testbench
==================================

ARBITER_4WAY_RR -- requirements
Module: arbiter_4way_rr

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 16, maximum cycles one grant is held before forced release (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port en, input, 1, arbitration enable; gates new grants only.
REQ-005 SHALL have port req, input, 4, request vector; bit i = requester i.
REQ-006 SHALL have port done, input, 1, single-cycle pulse from the shared resource ending the current transaction.
REQ-007 SHALL have port gnt, output, 4, registered one-hot grant.
REQ-008 SHALL have port gnt_id, output, 2, registered binary index of gnt.
REQ-009 SHALL have port busy, output, 1, high while in GRANT state.

Function
REQ-010 SHALL implement FSM with two states: IDLE and GRANT.
REQ-011 In IDLE with en=1 and req!=0, SHALL select the first set req bit searching upward from pointer ptr with wrap (ptr, ptr+1, ..., ptr+3 mod 4).
REQ-012 Selection SHALL be combinational from req and ptr; gnt/gnt_id/busy SHALL assert on the next rising edge (1-cycle request-to-grant latency).
REQ-013 In IDLE with en=0 or req=0, SHALL stay in IDLE with gnt=0, gnt_id unchanged, busy=0.
REQ-014 In GRANT, gnt and gnt_id SHALL be stable; req bits of other requesters SHALL be ignored.
REQ-015 GRANT SHALL exit to IDLE on the edge where any of: done=1; req[gnt_id]=0; hold counter = HOLD_MAX-1.
REQ-016 Hold counter SHALL clear to 0 on entry to GRANT and increment by 1 per GRANT cycle; width ceil(log2(HOLD_MAX)), no wrap reachable.
REQ-017 On GRANT exit, ptr SHALL update to gnt_id+1 mod 4 (3 wraps to 0); gnt SHALL be 0 for at least one cycle before any new grant (turnaround bubble).
REQ-018 Simultaneous exit conditions SHALL produce a single release with identical behaviour to any one alone.
REQ-019 done asserted in IDLE SHALL be ignored.
REQ-020 en deassertion during GRANT SHALL NOT abort the current grant.
REQ-021 gnt SHALL never have more than one bit set; gnt!=0 iff busy=1.

Reset
REQ-022 rst_n low SHALL immediately (asynchronously) force state=IDLE, gnt=0, gnt_id=0, busy=0, ptr=0, hold counter=0.
REQ-023 Reset asserted mid-GRANT SHALL drop gnt without waiting for done; first grant after reset SHALL favour requester 0.

Structure
REQ-024 FSM state encodings and HOLD_MAX default SHALL live in shared header arb_defs.vh as localparams/defines.
REQ-025 Rotating selection SHALL be a sub-module rr_pick4 (inputs req[3:0], ptr[1:0]; outputs hit, id[1:0]), purely combinational.
REQ-026 All outputs SHALL be driven directly from flops.

Verification
REQ-027 Reset, then req=4'b1111 en=1, done pulse each grant -> gnt sequence 0001,0010,0100,1000,0001 with one zero cycle between each.
REQ-028 ptr=0, req=4'b1010 -> gnt=0010, gnt_id=1; after release with req=4'b1010 held -> next gnt=1000.
REQ-029 Single requester req=4'b0100 held, no done, HOLD_MAX=16 -> gnt=0100 for exactly 16 cycles, 1 zero cycle, then re-granted 0100.
REQ-030 Grant to requester 2, then req[2]=0 and done=1 same cycle -> one release, ptr=3, busy=0 next cycle.
REQ-031 During GRANT drive en=0 -> grant held until done; afterwards no new grant while en=0 despite req=4'b1111.
REQ-032 rst_n pulsed low mid-GRANT (asynchronous to clk) -> gnt=0 before next edge; after release, req=4'b1001 -> gnt=0001.

Source files
------------

// File: rtl/arbiter_4way_rr_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Holds the FSM state encoding, the HOLD_MAX default and a one-hot helper.
package arbiter_4way_rr_pkg;

    localparam int unsigned NUM_REQ          = 4;
    localparam int unsigned HOLD_MAX_DEFAULT = 16;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] id2onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

endpackage

// File: rtl/arbiter_4way_rr_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The master side drives requests, enable and done; the slave (arbiter) drives the grant.
interface arbiter_4way_rr_if;
    import arbiter_4way_rr_pkg::*;

    logic               en;
    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         gnt_id;
    logic               busy;

    modport master (
        output en,
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  busy
    );

    modport slave (
        input  en,
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output busy
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational rotating priority picker: first set req bit at or above ptr, wrapping.
module rr_pick4
    import arbiter_4way_rr_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic               hit,
    output logic [1:0]         id
);

    logic [1:0] w_idx;

    // Scan from the farthest offset down so the nearest set bit to ptr wins.
    always_comb begin
        hit   = 1'b0;
        id    = ptr;
        w_idx = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = ptr + 2'(k);
            if (req[w_idx]) begin
                hit = 1'b1;
                id  = w_idx;
            end
        end
    end

endmodule

// File: rtl/arbiter_4way_rr.sv
// Four-requester round-robin arbiter with IDLE/GRANT FSM and bounded hold time.
// Every grant is followed by at least one idle cycle before the next one.
module arbiter_4way_rr
    import arbiter_4way_rr_pkg::*;
#(
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    arbiter_4way_rr_if.slave  io_bus
);

    localparam int unsigned CntW = $clog2(HOLD_MAX);

    arb_state_e         r_state, w_state_d;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_d;
    logic [1:0]         r_gnt_id, w_gnt_id_d;
    logic               r_busy, w_busy_d;
    logic [1:0]         r_ptr, w_ptr_d;
    logic [CntW-1:0]    r_cnt, w_cnt_d;

    logic               w_hit;
    logic [1:0]         w_pick_id;
    logic               w_release;

    rr_pick4 u_pick (
        .req (io_bus.req),
        .ptr (r_ptr),
        .hit (w_hit),
        .id  (w_pick_id)
    );

    assign w_release = io_bus.done || !io_bus.req[r_gnt_id] ||
                       (r_cnt == CntW'(HOLD_MAX - 1));

    always_comb begin
        w_state_d  = r_state;
        w_gnt_d    = r_gnt;
        w_gnt_id_d = r_gnt_id;
        w_busy_d   = r_busy;
        w_ptr_d    = r_ptr;
        w_cnt_d    = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (io_bus.en && w_hit) begin
                    w_state_d  = StGrant;
                    w_gnt_d    = id2onehot(w_pick_id);
                    w_gnt_id_d = w_pick_id;
                    w_busy_d   = 1'b1;
                    w_cnt_d    = '0;
                end
            end
            StGrant: begin
                if (w_release) begin
                    w_state_d = StIdle;
                    w_gnt_d   = '0;
                    w_busy_d  = 1'b0;
                    w_ptr_d   = r_gnt_id + 2'd1;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_gnt    <= '0;
            r_gnt_id <= 2'd0;
            r_busy   <= 1'b0;
            r_ptr    <= 2'd0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_gnt    <= w_gnt_d;
            r_gnt_id <= w_gnt_id_d;
            r_busy   <= w_busy_d;
            r_ptr    <= w_ptr_d;
            r_cnt    <= w_cnt_d;
        end
    end

    assign io_bus.gnt    = r_gnt;
    assign io_bus.gnt_id = r_gnt_id;
    assign io_bus.busy   = r_busy;

endmodule

// File: tb/tb_arbiter_4way_rr.sv
// Directed self-checking bench for arbiter_4way_rr with hand-computed grant sequences.
module tb_arbiter_4way_rr;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    arbiter_4way_rr_if bus ();

    arbiter_4way_rr #(
        .HOLD_MAX (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] seq [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;

        // Reset state
        do_reset();
        check_eq("rst_gnt", 32'(bus.gnt), 32'h0);
        check_eq("rst_gnt_id", 32'(bus.gnt_id), 32'h0);
        check_eq("rst_busy", 32'(bus.busy), 32'h0);

        // Full rotation with done pulses
        bus.req = 4'b1111;
        bus.en  = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("rot_gnt%0d", i), 32'(bus.gnt), 32'(seq[i]));
            check_eq($sformatf("rot_busy%0d", i), 32'(bus.busy), 32'h1);
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            check_eq($sformatf("rot_bubble%0d", i), 32'(bus.gnt), 32'h0);
            tick();
        end

        // Sparse request 1010 from ptr 0
        do_reset();
        bus.req = 4'b1010;
        bus.en  = 1'b1;
        tick();
        check_eq("sparse_gnt", 32'(bus.gnt), 32'h2);
        check_eq("sparse_id", 32'(bus.gnt_id), 32'h1);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check_eq("sparse_bubble", 32'(bus.gnt), 32'h0);
        tick();
        check_eq("sparse_next", 32'(bus.gnt), 32'h8);
        check_eq("sparse_next_id", 32'(bus.gnt_id), 32'h3);

        // Hold timeout: single requester held 16 cycles
        do_reset();
        bus.req = 4'b0100;
        bus.en  = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("hold_c%0d", i), 32'(bus.gnt), 32'h4);
            tick();
        end
        check_eq("hold_release", 32'(bus.gnt), 32'h0);
        check_eq("hold_release_busy", 32'(bus.busy), 32'h0);
        tick();
        check_eq("hold_regrant", 32'(bus.gnt), 32'h4);

        // Simultaneous req drop and done
        do_reset();
        bus.req = 4'b0100;
        bus.en  = 1'b1;
        tick();
        check_eq("sim_gnt", 32'(bus.gnt), 32'h4);
        bus.req  = 4'b0000;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check_eq("sim_busy", 32'(bus.busy), 32'h0);
        check_eq("sim_gnt_off", 32'(bus.gnt), 32'h0);
        check_eq("sim_id_kept", 32'(bus.gnt_id), 32'h2);
        bus.req = 4'b1111;
        tick();
        check_eq("sim_ptr3", 32'(bus.gnt), 32'h8);

        // en dropped mid-grant
        do_reset();
        bus.req = 4'b1111;
        bus.en  = 1'b1;
        tick();
        check_eq("en_gnt", 32'(bus.gnt), 32'h1);
        bus.en = 1'b0;
        tick();
        tick();
        check_eq("en_held", 32'(bus.gnt), 32'h1);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check_eq("en_release", 32'(bus.gnt), 32'h0);
        tick();
        tick();
        tick();
        check_eq("en_no_grant", 32'(bus.gnt), 32'h0);
        check_eq("en_no_busy", 32'(bus.busy), 32'h0);
        bus.en = 1'b1;
        tick();
        check_eq("en_resume", 32'(bus.gnt), 32'h2);

        // Asynchronous reset mid-grant
        do_reset();
        bus.req = 4'b0100;
        bus.en  = 1'b1;
        tick();
        check_eq("arst_pre", 32'(bus.gnt), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_gnt", 32'(bus.gnt), 32'h0);
        check_eq("arst_id", 32'(bus.gnt_id), 32'h0);
        check_eq("arst_busy", 32'(bus.busy), 32'h0);
        tick();
        rst_n   = 1'b1;
        bus.req = 4'b1001;
        tick();
        check_eq("arst_first", 32'(bus.gnt), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
